// File: rtl/zxuno_uart_pkg.sv
// Shared types and constants for the ZX-Uno UART transmitter.
// Defining ZXUNO_UART_TX_PARITY_EN adds the PARITY state and an even-parity bit (8E1).
package zxuno_uart_pkg;

  localparam int DEFAULT_DIVISOR = 28;
  localparam int DEFAULT_FIFO_AW = 4;
  localparam int DATA_BITS       = 8;

`ifdef ZXUNO_UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
  localparam int PARITY_BITS = 0;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif

  // start + data + optional parity + stop
  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: synchronously written RAM, head word always visible on rd_data,
// registered empty/full flags derived from an AW+1 bit occupancy counter.
module uart_tx_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_bus,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          do_wr, do_rd;

  // Flags are qualified with the registered state, so a write into a full FIFO
  // is dropped even when a pop happens on the same edge.
  always_comb begin
    do_wr    = wr_en & ~full_q;
    do_rd    = rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_rd};
    count_d  = count_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    empty_d  = (count_d == '0);
    full_d   = (count_d == FULL_COUNT);
  end

  always_ff @(posedge clk_bus) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk_bus or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;

endmodule

// File: rtl/zxuno_uart_tx.sv
// ZX-Uno UART transmitter: FIFO-fed 8N1 serialiser with registered txd.
// Defining ZXUNO_UART_TX_PARITY_EN switches the frame to 8E1.
module zxuno_uart_tx
  import zxuno_uart_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR,
  parameter int FIFO_AW = DEFAULT_FIFO_AW
) (
  input  logic       clk_bus,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       txd,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy
);

  localparam logic [15:0] BIT_RELOAD = 16'(DIVISOR - 1);

  tx_state_e   state_q, state_d;
  logic        txd_q, txd_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        bit_done;
  logic        pop;
  logic [7:0]  fifo_data;
  logic        fifo_empty, fifo_full;
`ifdef ZXUNO_UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  uart_tx_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
    .clk_bus (clk_bus),
    .reset_n (reset_n),
    .wr_en   (tx_req),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign bit_done = (baud_cnt_q == 16'd0);

  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    pop        = 1'b0;
`ifdef ZXUNO_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    if (state_q != IDLE) baud_cnt_d = bit_done ? BIT_RELOAD : baud_cnt_q - 16'd1;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_data;
`ifdef ZXUNO_UART_TX_PARITY_EN
          parity_d   = ^fifo_data;
`endif
          bit_cnt_d  = 3'd0;
          baud_cnt_d = BIT_RELOAD;
          txd_d      = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_done) begin
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = DATA;
        end
      end
      // bit_cnt_q numbers the data bit currently on the line
      DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef ZXUNO_UART_TX_PARITY_EN
            txd_d   = parity_q;
            state_d = PARITY;
`else
            txd_d   = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef ZXUNO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_data;
`ifdef ZXUNO_UART_TX_PARITY_EN
            parity_d  = ^fifo_data;
`endif
            bit_cnt_d = 3'd0;
            txd_d     = 1'b0;
            state_d   = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_bus or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      txd_q      <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
`ifdef ZXUNO_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
`ifdef ZXUNO_UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign txd      = txd_q;
  assign tx_full  = fifo_full;
  assign tx_empty = fifo_empty;
  assign tx_busy  = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_zxuno_uart_tx.sv
// Self-checking bench for zxuno_uart_tx (DIVISOR=4, FIFO_AW=2); expected frames are
// built from bytes by the serial frame rules, honouring ZXUNO_UART_TX_PARITY_EN.
module tb_zxuno_uart_tx;

  localparam int D = 4;
`ifdef ZXUNO_UART_TX_PARITY_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif

  logic       clk_bus;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       txd;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;

  int vectors;
  int miscompares;

  zxuno_uart_tx #(.DIVISOR(D), .FIFO_AW(2)) dut (
    .clk_bus  (clk_bus),
    .reset_n  (reset_n),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .txd      (txd),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .tx_busy  (tx_busy)
  );

  initial clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  // Serial line levels for one byte, index 0 = start bit; unused upper bits stay 1.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef ZXUNO_UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle write strobe; returns on the falling edge after the sampling edge.
  task automatic apply_stimulus(input logic [7:0] b);
    tx_data = b;
    tx_req  = 1'b1;
    @(negedge clk_bus);
    tx_req  = 1'b0;
    tx_data = 8'($urandom);
  endtask

  // Called on the falling edge inside cycle 'skip' of the frame; returns on the
  // falling edge just after the frame's last cycle.
  task automatic check_frame(input logic [7:0] b, input int skip);
    logic [10:0] f;
    f = frame_bits(b);
    for (int c = skip; c < FRAME_LEN * D; c++) begin
      check_output($sformatf("frame_%02h_c%0d", b, c), {7'd0, txd}, {7'd0, f[c / D]});
      if (c % D == 0) check_output($sformatf("busy_%02h_c%0d", b, c), {7'd0, tx_busy}, 8'd1);
      @(negedge clk_bus);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      check_output($sformatf("%s_txd_%0d", tag, c), {7'd0, txd}, 8'd1);
      check_output($sformatf("%s_busy_%0d", tag, c), {7'd0, tx_busy}, 8'd0);
      @(negedge clk_bus);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] rb;
    int n;

    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    tx_req      = 1'b0;
    tx_data     = 8'h00;

    repeat (2) @(negedge clk_bus);
    check_output("rst_txd",   {7'd0, txd},      8'd1);
    check_output("rst_empty", {7'd0, tx_empty}, 8'd1);
    check_output("rst_full",  {7'd0, tx_full},  8'd0);
    check_output("rst_busy",  {7'd0, tx_busy},  8'd0);
    reset_n = 1'b1;
    @(negedge clk_bus);
    check_idle("post_rst", 6);

    // Single 0xA5 frame with exact write-to-start latency
    apply_stimulus(8'hA5);
    check_output("lat_txd_hold", {7'd0, txd},      8'd1);
    check_output("lat_empty",    {7'd0, tx_empty}, 8'd0);
    check_output("lat_busy",     {7'd0, tx_busy},  8'd1);
    @(negedge clk_bus);
    check_frame(8'hA5, 0);
    check_idle("after_a5", 4);

    // Back-to-back 0x00 / 0xFF with no gap between stop and next start
    apply_stimulus(8'h00);
    apply_stimulus(8'hFF);
    check_frame(8'h00, 0);
    check_frame(8'hFF, 0);
    check_idle("after_b2b", 4);

    // Overfill a 4-deep FIFO while a frame is on the line
    rb = 8'($urandom);
    apply_stimulus(rb);
    @(negedge clk_bus);
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(8'(i));
      if (i == 3) check_output("full_after3", {7'd0, tx_full}, 8'd0);
      if (i >= 4) check_output($sformatf("full_after%0d", i), {7'd0, tx_full}, 8'd1);
    end
    check_output("full_not_empty", {7'd0, tx_empty}, 8'd0);
    check_frame(rb, 6);
    for (int i = 1; i <= 4; i++) check_frame(8'(i), 0);
    check_output("drain_empty", {7'd0, tx_empty}, 8'd1);
    check_idle("after_full", 4);

    // Random bursts of 1..3 bytes into an idle transmitter
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 3);
      q.delete();
      for (int i = 0; i < n; i++) begin
        rb = 8'($urandom);
        q.push_back(rb);
        apply_stimulus(rb);
      end
      if (n == 1) @(negedge clk_bus);
      check_frame(q.pop_front(), (n == 1) ? 0 : n - 2);
      while (q.size() > 0) check_frame(q.pop_front(), 0);
      check_idle($sformatf("rand%0d", r), 3);
    end

    // Reset at clock 13 of a 0x55 frame with two bytes still queued
    apply_stimulus(8'h55);
    apply_stimulus(8'($urandom));
    apply_stimulus(8'($urandom));
    repeat (11) @(negedge clk_bus);
    #2 reset_n = 1'b0;
    #1;
    check_output("mid_rst_txd",   {7'd0, txd},      8'd1);
    check_output("mid_rst_empty", {7'd0, tx_empty}, 8'd1);
    check_output("mid_rst_full",  {7'd0, tx_full},  8'd0);
    check_output("mid_rst_busy",  {7'd0, tx_busy},  8'd0);
    @(negedge clk_bus);
    reset_n = 1'b1;
    @(negedge clk_bus);
    check_idle("post_mid_rst", 50);

    // Reset during a start bit must raise txd without waiting for a clock
    apply_stimulus(8'($urandom));
    @(negedge clk_bus);
    check_output("start_low", {7'd0, txd}, 8'd0);
    #2 reset_n = 1'b0;
    #1;
    check_output("async_rst_txd", {7'd0, txd}, 8'd1);
    @(negedge clk_bus);
    reset_n = 1'b1;
    @(negedge clk_bus);
    check_idle("post_async_rst", 50);

`ifdef ZXUNO_UART_TX_PARITY_EN
    apply_stimulus(8'h07);
    @(negedge clk_bus);
    check_output("par07_bit", {7'd0, frame_bits(8'h07)[9]}, 8'd1);
    check_frame(8'h07, 0);
    apply_stimulus(8'h03);
    @(negedge clk_bus);
    check_output("par03_bit", {7'd0, frame_bits(8'h03)[9]}, 8'd0);
    check_frame(8'h03, 0);
    check_idle("after_parity", 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
